// File: rtl/outport_fifo_pkg.sv
// Shared constants for the output-port FIFO block: default sizes
// and the encodings selecting FIFO stream vs. legacy latch behaviour.
package outport_fifo_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_CHANNELS = 2;

    localparam int LATCH_FIFO = 0;
    localparam int LATCH_REG  = 1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/outport_fifo_chan.sv
// One output channel: flop storage, pointers, occupancy count and
// sticky overflow; in latch mode slot 0 doubles as the legacy register.
module outport_fifo_chan
    import outport_fifo_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATCH_MODE = LATCH_FIFO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ovf_clr,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              full,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam bit LATCH = (LATCH_MODE == LATCH_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              ovf_q;
    logic              at_cap;
    logic              pop;
    logic              push;

    assign at_cap   = (count == (AW+1)'(DEPTH));
    assign valid    = (count != '0);
    assign pop      = !LATCH && valid && ready;
    // A full channel still takes a word when the head leaves this cycle
    assign push     = wr && (!at_cap || pop);
    assign full     = !LATCH && at_cap;
    assign overflow = ovf_q;
    assign data     = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (LATCH) begin
            if (wr) begin
                mem[0] <= wdata;
                count  <= (AW+1)'(1);
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            // A fresh drop outranks a same-cycle clear
            if (wr && !push)  ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

endmodule

// File: rtl/outport_fifo.sv
// Multi-channel output port: decodes the write strobe to one channel
// and replicates the per-channel FIFO/latch slice.
module outport_fifo
    import outport_fifo_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int LATCH_MODE = LATCH_FIFO,
    localparam int SEL_W     = sel_width(CHANNELS)
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [DATA_W-1:0]          BusMuxOut,
    input  logic                       OutPortin,
    input  logic [SEL_W-1:0]           ChanSel,
    input  logic [CHANNELS-1:0]        OvfClr,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic [CHANNELS-1:0]        out_valid,
    input  logic [CHANNELS-1:0]        out_ready,
    output logic [CHANNELS-1:0]        full,
    output logic [CHANNELS-1:0]        overflow
);

    // Out-of-range selects match no channel and so are dropped silently
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        logic hit;

        assign hit = OutPortin && (ChanSel == SEL_W'(k));

        outport_fifo_chan #(
            .DATA_W     (DATA_W),
            .DEPTH      (DEPTH),
            .LATCH_MODE (LATCH_MODE)
        ) u_chan (
            .clk      (Clock),
            .rst_n    (Reset),
            .wr       (hit),
            .wdata    (BusMuxOut),
            .ovf_clr  (OvfClr[k]),
            .ready    (out_ready[k]),
            .data     (out_data[k*DATA_W +: DATA_W]),
            .valid    (out_valid[k]),
            .full     (full[k]),
            .overflow (overflow[k])
        );
    end

endmodule

// File: tb/tb_outport_fifo.sv
// Scoreboard bench for outport_fifo: FIFO instance (2 ch, depth 4)
// plus a latch-mode instance (3 ch) for the legacy register path.
module tb_outport_fifo;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] din;
    logic        wr;
    logic [0:0]  sel;
    logic [1:0]  clr;
    logic [1:0]  rdy;
    logic [63:0] odata;
    logic [1:0]  ovalid;
    logic [1:0]  ofull;
    logic [1:0]  oovf;

    logic [15:0] l_din;
    logic        l_wr;
    logic [1:0]  l_sel;
    logic [2:0]  l_clr;
    logic [2:0]  l_rdy;
    logic [47:0] l_data;
    logic [2:0]  l_valid;
    logic [2:0]  l_full;
    logic [2:0]  l_ovf;

    typedef struct {
        int          ch;
        logic [31:0] d;
    } ent_t;

    ent_t       sb[$];
    logic [1:0] ovf_m;
    int         n_chk;
    int         n_pass;

    always #5 Clock = ~Clock;

    outport_fifo #(
        .DATA_W(32), .DEPTH(4), .CHANNELS(2), .LATCH_MODE(0)
    ) dut (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(din),
        .OutPortin(wr), .ChanSel(sel), .OvfClr(clr),
        .out_data(odata), .out_valid(ovalid), .out_ready(rdy),
        .full(ofull), .overflow(oovf)
    );

    outport_fifo #(
        .DATA_W(16), .DEPTH(4), .CHANNELS(3), .LATCH_MODE(1)
    ) dut_latch (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(l_din),
        .OutPortin(l_wr), .ChanSel(l_sel), .OvfClr(l_clr),
        .out_data(l_data), .out_valid(l_valid), .out_ready(l_rdy),
        .full(l_full), .overflow(l_ovf)
    );

    function automatic int head_idx(input int k);
        foreach (sb[i]) if (sb[i].ch == k) return i;
        return -1;
    endfunction

    function automatic int cnt(input int k);
        int c = 0;
        foreach (sb[i]) if (sb[i].ch == k) c++;
        return c;
    endfunction

    // Evaluate pops/pushes for this cycle, then advance one edge
    task automatic tick();
        int   c[2];
        logic p[2];
        int   h;
        logic acc = 1'b1;
        for (int k = 0; k < 2; k++) begin
            c[k] = cnt(k);
            p[k] = ovalid[k] && rdy[k];
        end
        for (int k = 0; k < 2; k++) begin
            if (p[k]) begin
                h = head_idx(k);
                n_chk++;
                if (h < 0)
                    $display("FAIL pop_ch%0d: got %h, required no word",
                             k, odata[k*32 +: 32]);
                else if (odata[k*32 +: 32] !== sb[h].d)
                    $display("FAIL pop_ch%0d: got %h, required %h",
                             k, odata[k*32 +: 32], sb[h].d);
                else
                    n_pass++;
                if (h >= 0) sb.delete(h);
            end
        end
        if (wr) begin
            acc = (c[sel] < 4) || p[sel];
            if (acc) sb.push_back('{int'(sel), din});
            else     ovf_m[sel] = 1'b1;
        end
        for (int k = 0; k < 2; k++)
            if (clr[k] && !(wr && int'(sel) == k && !acc))
                ovf_m[k] = 1'b0;
        @(posedge Clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (ovalid[k] !== (cnt(k) != 0))
                $display("FAIL valid_ch%0d: got %b, required %b",
                         k, ovalid[k], cnt(k) != 0);
            else
                n_pass++;
            n_chk++;
            if (oovf[k] !== ovf_m[k])
                $display("FAIL ovf_ch%0d: got %b, required %b",
                         k, oovf[k], ovf_m[k]);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if ({ovalid, ofull, oovf} !== 6'b0)
            $display("FAIL reset_flags: got %b, required 000000",
                     {ovalid, ofull, oovf});
        else n_pass++;
        n_chk++;
        if (odata !== 64'h0)
            $display("FAIL reset_data: got %h, required 0", odata);
        else n_pass++;
        n_chk++;
        if (l_valid !== 3'b000 || l_data !== 48'h0)
            $display("FAIL reset_latch: got %b/%h, required 000/0",
                     l_valid, l_data);
        else n_pass++;
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        n_chk++;
        if (ovalid !== 2'b00)
            $display("FAIL reset_release: got %b, required 00", ovalid);
        else n_pass++;
    endtask

    task automatic test_basic();
        rdy = 2'b00; wr = 1'b1; sel = 1'b0;
        din = 32'h11111111;
        n_chk++;
        if (ovalid[0] !== 1'b0)
            $display("FAIL no_fallthrough: got %b, required 0", ovalid[0]);
        else n_pass++;
        tick();
        n_chk++;
        if (ovalid[0] !== 1'b1 || odata[31:0] !== 32'h11111111)
            $display("FAIL basic_first: got %b/%h, required 1/11111111",
                     ovalid[0], odata[31:0]);
        else n_pass++;
        din = 32'h22222222;
        tick();
        wr = 1'b0; rdy = 2'b01;
        tick();
        tick();
        n_chk++;
        if (ovalid[0] !== 1'b0 || odata[31:0] !== 32'h0)
            $display("FAIL basic_empty: got %b/%h, required 0/0",
                     ovalid[0], odata[31:0]);
        else n_pass++;
        rdy = 2'b00;
    endtask

    task automatic test_overflow();
        rdy = 2'b00; sel = 1'b1; wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 32'hA0 + i;
            tick();
            if (i == 3) begin
                n_chk++;
                if (ofull[1] !== 1'b1)
                    $display("FAIL full_at_4: got %b, required 1", ofull[1]);
                else n_pass++;
            end
        end
        n_chk++;
        if (oovf !== 2'b10)
            $display("FAIL ovf_set: got %b, required 10", oovf);
        else n_pass++;
        wr = 1'b0; rdy = 2'b10;
        repeat (4) tick();
        n_chk++;
        if (ovalid[1] !== 1'b0 || ofull[1] !== 1'b0)
            $display("FAIL ovf_drain: got %b/%b, required 0/0",
                     ovalid[1], ofull[1]);
        else n_pass++;
        rdy = 2'b00; clr = 2'b10;
        tick();
        clr = 2'b00;
        n_chk++;
        if (oovf[1] !== 1'b0)
            $display("FAIL ovf_clear: got %b, required 0", oovf[1]);
        else n_pass++;
    endtask

    task automatic test_full_pop_push();
        rdy = 2'b00; sel = 1'b1; wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 32'hC0 + i;
            tick();
        end
        rdy = 2'b10; din = 32'hBEEF;
        tick();
        n_chk++;
        if (ofull[1] !== 1'b1 || oovf[1] !== 1'b0)
            $display("FAIL full_pop_push: got full=%b ovf=%b, required 1/0",
                     ofull[1], oovf[1]);
        else n_pass++;
        wr = 1'b0;
        repeat (4) tick();
        n_chk++;
        if (ovalid[1] !== 1'b0)
            $display("FAIL full_pop_drain: got %b, required 0", ovalid[1]);
        else n_pass++;
        rdy = 2'b00;
    endtask

    task automatic test_wrap();
        rdy = 2'b00; wr = 1'b1; sel = 1'b0; din = 32'h0C0C0C0C;
        tick();
        sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 32'hD0 + i;
            tick();
        end
        wr = 1'b0; rdy = 2'b10;
        tick();
        tick();
        wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdy = (i % 2 == 1) ? 2'b10 : 2'b00;
            din = 32'hE0 + i;
            tick();
        end
        wr = 1'b0; rdy = 2'b10;
        for (int i = 0; i < 8 && ovalid[1]; i++) tick();
        n_chk++;
        if (ovalid[1] !== 1'b0)
            $display("FAIL wrap_drain: got %b, required 0", ovalid[1]);
        else n_pass++;
        n_chk++;
        if (ovalid[0] !== 1'b1 || odata[31:0] !== 32'h0C0C0C0C)
            $display("FAIL wrap_isolation: got %b/%h, required 1/0c0c0c0c",
                     ovalid[0], odata[31:0]);
        else n_pass++;
        rdy = 2'b01;
        tick();
        rdy = 2'b00;
    endtask

    task automatic test_reset_mid();
        rdy = 2'b00; wr = 1'b1; sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 32'hF1 + i;
            tick();
        end
        wr = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        n_chk++;
        if (ovalid !== 2'b00 || odata !== 64'h0 || ofull !== 2'b00)
            $display("FAIL async_reset: got %b/%h/%b, required 00/0/00",
                     ovalid, odata, ofull);
        else n_pass++;
        sb.delete();
        ovf_m = 2'b00;
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        wr = 1'b1; din = 32'h5;
        tick();
        wr = 1'b0;
        n_chk++;
        if (ovalid !== 2'b01 || odata[31:0] !== 32'h5)
            $display("FAIL post_reset_write: got %b/%h, required 01/5",
                     ovalid, odata[31:0]);
        else n_pass++;
        rdy = 2'b01;
        tick();
        rdy = 2'b00;
        n_chk++;
        if (ovalid !== 2'b00)
            $display("FAIL post_reset_alone: got %b, required 00", ovalid);
        else n_pass++;
    endtask

    task automatic test_latch();
        l_rdy = 3'b111;
        n_chk++;
        if (l_valid !== 3'b000)
            $display("FAIL latch_idle: got %b, required 000", l_valid);
        else n_pass++;
        l_wr = 1'b1; l_sel = 2'd2; l_din = 16'h1234;
        tick();
        n_chk++;
        if (l_data[47:32] !== 16'h1234 || l_valid !== 3'b100)
            $display("FAIL latch_first: got %h/%b, required 1234/100",
                     l_data[47:32], l_valid);
        else n_pass++;
        l_din = 16'h5678;
        tick();
        l_wr = 1'b0;
        tick();
        n_chk++;
        if (l_data[47:32] !== 16'h5678 || l_valid !== 3'b100)
            $display("FAIL latch_second: got %h/%b, required 5678/100",
                     l_data[47:32], l_valid);
        else n_pass++;
        l_wr = 1'b1; l_sel = 2'd3; l_din = 16'hFFFF;
        tick();
        n_chk++;
        if (l_valid !== 3'b100 || l_data !== {16'h5678, 32'h0})
            $display("FAIL bad_sel: got %b/%h, required 100/567800000000",
                     l_valid, l_data);
        else n_pass++;
        l_sel = 2'd0;
        for (int i = 0; i < 6; i++) begin
            l_din = 16'h0100 + 16'(i);
            tick();
        end
        l_wr = 1'b0;
        n_chk++;
        if (l_full !== 3'b000 || l_ovf !== 3'b000)
            $display("FAIL latch_flags: got %b/%b, required 000/000",
                     l_full, l_ovf);
        else n_pass++;
        n_chk++;
        if (l_data[15:0] !== 16'h0105 || l_valid !== 3'b101)
            $display("FAIL latch_last: got %h/%b, required 0105/101",
                     l_data[15:0], l_valid);
        else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; ovf_m = 2'b00;
        din = '0; wr = 1'b0; sel = '0; clr = '0; rdy = '0;
        l_din = '0; l_wr = 1'b0; l_sel = '0; l_clr = '0; l_rdy = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop_push();
        test_wrap();
        test_reset_mid();
        test_latch();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/outport_fifo.md
OUTPORT_FIFO -- requirements
Module: outport_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each output word.
REQ-002 SHALL have parameter DEPTH, default 4, meaning per-channel FIFO entries; power of two and at least 2.
REQ-003 SHALL have parameter CHANNELS, default 2, meaning number of independent output ports; at least 1.
REQ-004 SHALL have parameter LATCH_MODE, default 0, meaning 1 = legacy single-register out port, 0 = FIFO stream.
REQ-005 SHALL have port Clock  input  1  single system clock; all state changes on rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port BusMuxOut  input  DATA_W  datapath bus word to be written.
REQ-008 SHALL have port OutPortin  input  1  write strobe; one word per high cycle.
REQ-009 SHALL have port ChanSel  input  max(1,clog2(CHANNELS))  target channel of the write.
REQ-010 SHALL have port OvfClr  input  CHANNELS  per-channel overflow-flag clear.
REQ-011 SHALL have port out_data  output  CHANNELS*DATA_W  head word per channel; channel k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port out_valid  output  CHANNELS  head word valid per channel.
REQ-013 SHALL have port out_ready  input  CHANNELS  external consumer accepts head word.
REQ-014 SHALL have port full  output  CHANNELS  channel cannot accept a write.
REQ-015 SHALL have port overflow  output  CHANNELS  sticky dropped-write flag.

Function
REQ-016 SHALL treat a write as OutPortin=1 at a rising edge, directed to channel ChanSel; a ChanSel value >= CHANNELS SHALL be ignored, with no state change.
REQ-017 FIFO mode: push SHALL occur when write && !full[k]; pop SHALL occur when out_valid[k] && out_ready[k].
REQ-018 FIFO mode: a pushed word SHALL appear on out_data[k] with out_valid[k]=1 at the next edge (latency 1, no same-cycle fall-through).
REQ-019 FIFO mode: out_data[k] SHALL be 0 whenever out_valid[k]=0.
REQ-020 Per-channel count SHALL be clog2(DEPTH)+1 bits; full[k]=(count==DEPTH); out_valid[k]=(count!=0).
REQ-021 Read and write pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 Write while full with no same-cycle pop: word SHALL be dropped and overflow[k] SHALL be set at that edge.
REQ-023 Write while full with a same-cycle pop: word SHALL be accepted and count SHALL remain DEPTH; overflow SHALL NOT be set.
REQ-024 Push and pop in the same cycle on a non-empty channel SHALL leave count unchanged.
REQ-025 overflow[k] SHALL remain set until OvfClr[k]=1; a clear and a new overflow in the same cycle SHALL leave it set.
REQ-026 LATCH_MODE=1: each write SHALL load out_data[k] at the next edge; out_valid[k] SHALL be 1 from the first write until reset; out_ready SHALL be ignored; full and overflow SHALL be 0.
REQ-027 Channels SHALL be fully independent; activity on one SHALL NOT change another's state.

Reset
REQ-028 Reset=0 SHALL immediately, asynchronously, clear all pointers, counts, the latch register, out_data, out_valid, full and overflow to 0.
REQ-029 Reset asserted mid-stream SHALL discard all queued words; the first write after deassertion SHALL be at position 0.
REQ-030 Deassertion SHALL take effect at the first rising edge after Reset returns high.

Structure
REQ-031 A shared package SHALL hold the default DATA_W/DEPTH/CHANNELS constants and the LATCH_MODE encodings.
REQ-032 The top level SHALL instantiate one sub-module, outport_fifo_chan (one channel's storage, pointers, count, overflow), CHANNELS times through a generate loop.
REQ-033 Storage SHALL be flip-flops; the head word SHALL be read combinationally from the read pointer and gated by out_valid.

Verification
REQ-034 Write 0x11111111, 0x22222222 to channel 0 with out_ready=0, then ready=1 -> out_valid[0] rises 1 cycle after the first write; words pop in order; count returns to 0.
REQ-035 DEPTH=4: write 5 words 0xA0..0xA4 to channel 1, ready=0 -> full[1]=1 after the 4th word; 0xA4 is dropped; overflow[1]=1; drain gives 0xA0..0xA3; OvfClr[1] clears the flag.
REQ-036 Channel full and ready=1 and a write of 0xBEEF in the same cycle -> pop accepted, 0xBEEF enqueued, full stays 1, overflow stays 0.
REQ-037 Push 3 words, pop 2, push 4 with alternating ready -> pointer wrap is exercised; output order is exact; channel 0 is unaffected.
REQ-038 Reset pulled low mid-cycle with 3 words queued -> outputs go to 0 before the next edge; a subsequent write of 0x5 appears alone.
REQ-039 LATCH_MODE=1: write 0x1234 then 0x5678 with out_ready=0 -> out_data=0x1234 then 0x5678; out_valid stays 1; full and overflow stay 0.
